// File: rtl/conv_seq.sv
// conv_seq -- convolution loop sequencer for the tiny_dnn_core array.
//
// Walks output pixels (y outer, x), input channels (c) and kernel taps
// (ky, kx innermost). For every pixel it emits one k_init pulse, then
// N = id*kh*kw consecutive exec cycles carrying the src address ia and
// weight address wa, then one k_fin pulse. The next pixel's k_init waits
// while out_busy is high (checked only in WAIT and FIN).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin one sample (accepted only in IDLE)
//   backprop          rotated-kernel weight order, latched at start
//   out_busy          output drain busy, stalls the next pixel
//   id, is, iw        input channel count, channel stride, input width
//   oh, ow            output height / width
//   kh, kw, ks        kernel height / width, kernel stride per channel
//   busy, done        sample in progress / end-of-sample pulse
//   k_init, exec      accumulator clear pulse / accumulate strobe
//   ia, wa            src buffer address / weight address (0 when idle)
//   k_fin             pulse after the last exec of a pixel
//
// Build option: CONV_SEQ_BACKPROP_EN -- when defined, a latched backprop=1
// replaces the tap index t with ks-1-t on wa (kernel rotated 180 degrees).
// When undefined the backprop port is ignored.
//
// All addresses are built from running sums; no multiplier is used.

module conv_seq #(
    parameter int IA_W = 12,
    parameter int WA_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            backprop,
    input  logic            out_busy,
    input  logic [3:0]      id,
    input  logic [9:0]      is,
    input  logic [4:0]      iw,
    input  logic [4:0]      oh,
    input  logic [4:0]      ow,
    input  logic [4:0]      kh,
    input  logic [4:0]      kw,
    input  logic [9:0]      ks,
    output logic            busy,
    output logic            done,
    output logic            k_init,
    output logic            exec,
    output logic [IA_W-1:0] ia,
    output logic [WA_W-1:0] wa,
    output logic            k_fin
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_INIT, S_EXEC, S_FIN, S_DONE
    } state_t;

    state_t state_q, state_d;

    // Latched dimensions
    logic [3:0] id_q, id_d;
    logic [9:0] is_q, is_d, ks_q, ks_d;
    logic [4:0] iw_q, iw_d, oh_q, oh_d, ow_q, ow_d, kh_q, kh_d, kw_q, kw_d;

    // Loop counters; the tap counters point at the tap issued next
    logic [4:0] y_q, y_d, x_q, x_d, ky_q, ky_d, kx_q, kx_d;
    logic [3:0] c_q, c_d;
    logic [9:0] t_q, t_d;

    // Running address terms:
    //   row_base = y*iw, pix_off = y*iw + x, tap_row = ky*iw,
    //   chan_base = c*is, wchan = c*ks
    logic [IA_W-1:0] row_base_q, row_base_d, pix_off_q, pix_off_d;
    logic [IA_W-1:0] tap_row_q, tap_row_d, chan_base_q, chan_base_d;
    logic [WA_W-1:0] wchan_q, wchan_d;

    // Set when the tap just issued was the last one of the pixel
    logic last_q, last_d;

    logic            busy_q, busy_d, done_q, done_d, k_init_q, k_init_d;
    logic            exec_q, exec_d, k_fin_q, k_fin_d;
    logic [IA_W-1:0] ia_q, ia_d;
    logic [WA_W-1:0] wa_q, wa_d, tap_sel;
    logic            issue;

`ifdef CONV_SEQ_BACKPROP_EN
    logic bp_q, bp_d;
`else
    logic unused_backprop;
    assign unused_backprop = backprop;
`endif

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        is_d        = is_q;
        ks_d        = ks_q;
        iw_d        = iw_q;
        oh_d        = oh_q;
        ow_d        = ow_q;
        kh_d        = kh_q;
        kw_d        = kw_q;
        y_d         = y_q;
        x_d         = x_q;
        c_d         = c_q;
        ky_d        = ky_q;
        kx_d        = kx_q;
        t_d         = t_q;
        row_base_d  = row_base_q;
        pix_off_d   = pix_off_q;
        tap_row_d   = tap_row_q;
        chan_base_d = chan_base_q;
        wchan_d     = wchan_q;
        last_d      = 1'b0;
        issue       = 1'b0;
        exec_d      = 1'b0;
        ia_d        = '0;
        wa_d        = '0;
`ifdef CONV_SEQ_BACKPROP_EN
        bp_d        = bp_q;
        tap_sel     = bp_q ? WA_W'(ks_q - 10'd1 - t_q) : WA_W'(t_q);
`else
        tap_sel     = WA_W'(t_q);
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    id_d        = id;
                    is_d        = is;
                    ks_d        = ks;
                    iw_d        = iw;
                    oh_d        = oh;
                    ow_d        = ow;
                    kh_d        = kh;
                    kw_d        = kw;
`ifdef CONV_SEQ_BACKPROP_EN
                    bp_d        = backprop;
`endif
                    y_d         = '0;
                    x_d         = '0;
                    c_d         = '0;
                    ky_d        = '0;
                    kx_d        = '0;
                    t_d         = '0;
                    row_base_d  = '0;
                    pix_off_d   = '0;
                    tap_row_d   = '0;
                    chan_base_d = '0;
                    wchan_d     = '0;
                    if (oh == 5'd0 || ow == 5'd0 || id == 4'd0 ||
                        kh == 5'd0 || kw == 5'd0)
                        state_d = S_DONE;
                    else
                        state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!out_busy)
                    state_d = S_INIT;
            end
            S_INIT: begin
                state_d = S_EXEC;
                issue   = 1'b1;
            end
            S_EXEC: begin
                if (last_q)
                    state_d = S_FIN;
                else
                    issue = 1'b1;
            end
            S_FIN: begin
                if (y_q == oh_q - 5'd1 && x_q == ow_q - 5'd1) begin
                    state_d = S_DONE;
                end else begin
                    // Tap counters already wrapped to 0 on the last tap;
                    // only the channel terms need rewinding.
                    c_d         = '0;
                    chan_base_d = '0;
                    wchan_d     = '0;
                    if (x_q != ow_q - 5'd1) begin
                        x_d       = x_q + 5'd1;
                        pix_off_d = pix_off_q + 1'b1;
                    end else begin
                        x_d        = '0;
                        y_d        = y_q + 5'd1;
                        row_base_d = row_base_q + IA_W'(iw_q);
                        pix_off_d  = row_base_q + IA_W'(iw_q);
                    end
                    state_d = out_busy ? S_WAIT : S_INIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            exec_d = 1'b1;
            ia_d   = chan_base_q + pix_off_q + tap_row_q + IA_W'(kx_q);
            wa_d   = wchan_q + tap_sel;
            last_d = (c_q == id_q - 4'd1) && (ky_q == kh_q - 5'd1) &&
                     (kx_q == kw_q - 5'd1);
            if (kx_q != kw_q - 5'd1) begin
                kx_d = kx_q + 5'd1;
                t_d  = t_q + 10'd1;
            end else begin
                kx_d = '0;
                if (ky_q != kh_q - 5'd1) begin
                    ky_d      = ky_q + 5'd1;
                    tap_row_d = tap_row_q + IA_W'(iw_q);
                    t_d       = t_q + 10'd1;
                end else begin
                    ky_d        = '0;
                    tap_row_d   = '0;
                    t_d         = '0;
                    c_d         = c_q + 4'd1;
                    chan_base_d = chan_base_q + IA_W'(is_q);
                    wchan_d     = wchan_q + WA_W'(ks_q);
                end
            end
        end

        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        k_init_d = (state_d == S_INIT);
        k_fin_d  = (state_d == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            is_q        <= '0;
            ks_q        <= '0;
            iw_q        <= '0;
            oh_q        <= '0;
            ow_q        <= '0;
            kh_q        <= '0;
            kw_q        <= '0;
            y_q         <= '0;
            x_q         <= '0;
            c_q         <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            t_q         <= '0;
            row_base_q  <= '0;
            pix_off_q   <= '0;
            tap_row_q   <= '0;
            chan_base_q <= '0;
            wchan_q     <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            k_init_q    <= 1'b0;
            exec_q      <= 1'b0;
            k_fin_q     <= 1'b0;
            ia_q        <= '0;
            wa_q        <= '0;
`ifdef CONV_SEQ_BACKPROP_EN
            bp_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            is_q        <= is_d;
            ks_q        <= ks_d;
            iw_q        <= iw_d;
            oh_q        <= oh_d;
            ow_q        <= ow_d;
            kh_q        <= kh_d;
            kw_q        <= kw_d;
            y_q         <= y_d;
            x_q         <= x_d;
            c_q         <= c_d;
            ky_q        <= ky_d;
            kx_q        <= kx_d;
            t_q         <= t_d;
            row_base_q  <= row_base_d;
            pix_off_q   <= pix_off_d;
            tap_row_q   <= tap_row_d;
            chan_base_q <= chan_base_d;
            wchan_q     <= wchan_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            k_init_q    <= k_init_d;
            exec_q      <= exec_d;
            k_fin_q     <= k_fin_d;
            ia_q        <= ia_d;
            wa_q        <= wa_d;
`ifdef CONV_SEQ_BACKPROP_EN
            bp_q        <= bp_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign k_init = k_init_q;
    assign exec   = exec_q;
    assign ia     = ia_q;
    assign wa     = wa_q;
    assign k_fin  = k_fin_q;

endmodule

// File: tb/tb_conv_seq.sv
// tb_conv_seq -- self-checking bench for conv_seq.
// Each sample run is compared cycle by cycle against an expected trace
// built from nested loops over the output pixels, channels and taps.

`timescale 1ns/1ps

module tb_conv_seq;

    localparam int IA_W = 12;
    localparam int WA_W = 10;

    logic            clk = 1'b0;
    logic            rst, start, backprop, out_busy;
    logic [3:0]      id;
    logic [9:0]      is_i, ks;
    logic [4:0]      iw, oh, ow, kh, kw;
    logic            busy, done, k_init, exec, k_fin;
    logic [IA_W-1:0] ia;
    logic [WA_W-1:0] wa;

    always #5 clk = ~clk;

    conv_seq #(.IA_W(IA_W), .WA_W(WA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .backprop(backprop),
        .out_busy(out_busy), .id(id), .is(is_i), .iw(iw), .oh(oh),
        .ow(ow), .kh(kh), .kw(kw), .ks(ks), .busy(busy), .done(done),
        .k_init(k_init), .exec(exec), .ia(ia), .wa(wa), .k_fin(k_fin)
    );

    typedef struct {
        int id, iw, ih, oh, ow, kh, kw;
        bit bp;
        int exp_fins;   // -1: not checked
        int exp_done;   // cycle of done relative to the start cycle
    } vec_t;

    typedef struct packed {
        logic            busy, done, k_init, exec, k_fin;
        logic [IA_W-1:0] ia;
        logic [WA_W-1:0] wa;
    } rec_t;

    rec_t exp_q[$];
    int   act_ia[$], act_wa[$];
    int   fins, done_at, stall_fin_idx;
    int   tests_run = 0, tests_failed = 0;

    function automatic rec_t mk(bit b, bit d, bit ki, bit ex, bit kf, int a, int w);
        rec_t r;
        r.busy = b; r.done = d; r.k_init = ki; r.exec = ex; r.k_fin = kf;
        r.ia = IA_W'(a); r.wa = WA_W'(w);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        tests_run++;
        if (act != expv) begin
            tests_failed++;
            $display("FAIL %s: got %0d, want %0d", name, act, expv);
        end
    endtask

    task automatic drive_cfg(input vec_t v);
        id = 4'(v.id); iw = 5'(v.iw); oh = 5'(v.oh); ow = 5'(v.ow);
        kh = 5'(v.kh); kw = 5'(v.kw);
        is_i = 10'(v.ih * v.iw); ks = 10'(v.kh * v.kw);
        backprop = v.bp;
    endtask

    // Expected per-cycle trace, starting with the cycle after start.
    task automatic build(input vec_t v, input int stall_pix, input int stall_len);
        int is_v, ks_v, t;
        exp_q.delete();
        stall_fin_idx = -1;
        is_v = v.ih * v.iw;
        ks_v = v.kh * v.kw;
        if (v.id == 0 || v.oh == 0 || v.ow == 0 || v.kh == 0 || v.kw == 0) begin
            exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            return;
        end
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        for (int y = 0; y < v.oh; y++)
            for (int x = 0; x < v.ow; x++) begin
                exp_q.push_back(mk(1, 0, 1, 0, 0, 0, 0));
                for (int c = 0; c < v.id; c++)
                    for (int ky = 0; ky < v.kh; ky++)
                        for (int kx = 0; kx < v.kw; kx++) begin
                            t = ky * v.kw + kx;
`ifdef CONV_SEQ_BACKPROP_EN
                            if (v.bp) t = ks_v - 1 - t;
`endif
                            exp_q.push_back(mk(1, 0, 0, 1, 0,
                                (c * is_v + (y + ky) * v.iw + x + kx) % 4096,
                                (c * ks_v + t) % 1024));
                        end
                exp_q.push_back(mk(1, 0, 0, 0, 1, 0, 0));
                if (y * v.ow + x == stall_pix) begin
                    stall_fin_idx = exp_q.size() - 1;
                    for (int s = 0; s < stall_len; s++)
                        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
                end
            end
        exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic run(input int tag, input vec_t v, input int stall_pix,
                       input int stall_len, input bit noise);
        rec_t a, bad_a, bad_e;
        int   bad, n;
        build(v, stall_pix, stall_len);
        n = exp_q.size();
        act_ia.delete(); act_wa.delete();
        fins = 0; done_at = -1; bad = -1;
        bad_a = '0; bad_e = '0;
        @(posedge clk); #1;
        drive_cfg(v);
        start = 1'b1;
        out_busy = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            a = mk(busy, done, k_init, exec, k_fin, int'(ia), int'(wa));
            if (a != exp_q[i] && bad < 0) begin
                bad = i; bad_a = a; bad_e = exp_q[i];
            end
            if (k_fin) fins++;
            if (done && done_at < 0) done_at = i + 1;
            if (exec) begin
                act_ia.push_back(int'(ia));
                act_wa.push_back(int'(wa));
            end
            // Inputs set now are seen during cycle i.
            start = (noise && i < n - 1) ? 1'($urandom) : 1'b0;
            if (stall_fin_idx >= 0 && i >= stall_fin_idx && i < stall_fin_idx + stall_len)
                out_busy = 1'b1;
            else if (noise && (exp_q[i].exec || exp_q[i].k_init))
                out_busy = 1'($urandom);
            else
                out_busy = 1'b0;
            if (noise) begin
                id = 4'($urandom); iw = 5'($urandom); oh = 5'($urandom);
                ow = 5'($urandom); kh = 5'($urandom); kw = 5'($urandom);
                is_i = 10'($urandom); ks = 10'($urandom); backprop = 1'($urandom);
            end
        end
        start = 1'b0;
        out_busy = 1'b0;
        tests_run++;
        if (bad >= 0) begin
            tests_failed++;
            $display("FAIL trace run %0d cycle %0d: got b/d/ki/ex/kf=%b%b%b%b%b ia=%0d wa=%0d, want %b%b%b%b%b ia=%0d wa=%0d",
                     tag, bad + 1, bad_a.busy, bad_a.done, bad_a.k_init, bad_a.exec,
                     bad_a.k_fin, bad_a.ia, bad_a.wa, bad_e.busy, bad_e.done,
                     bad_e.k_init, bad_e.exec, bad_e.k_fin, bad_e.ia, bad_e.wa);
        end
        if (v.exp_fins >= 0) begin
            chk($sformatf("fins run %0d", tag), fins, v.exp_fins);
            chk($sformatf("done_at run %0d", tag), done_at, v.exp_done);
        end
        $display("[TB] run %0d: id=%0d oh=%0d ow=%0d kh=%0d kw=%0d bp=%0d stall=%0d cycles=%0d fins=%0d execs=%0d",
                 tag, v.id, v.oh, v.ow, v.kh, v.kw, v.bp, stall_len, n, fins, act_ia.size());
    endtask

    vec_t vecs[8];
    vec_t rv;
    int   tap_ia1[4], tap_ia3[4], two_ia0[8], bp_wa0[4];
    int   seen;

    initial begin
        rst = 1'b1; start = 1'b0; backprop = 1'b0; out_busy = 1'b0;
        id = '0; is_i = '0; iw = '0; oh = '0; ow = '0; kh = '0; kw = '0; ks = '0;

        //           id iw ih oh ow kh kw bp fins done
        vecs[0] = '{1, 1, 1, 1, 1, 1, 1, 0, 1,   5};    // minimal
        vecs[1] = '{1, 3, 3, 2, 2, 2, 2, 0, 4,   26};   // tap ordering
        vecs[2] = '{2, 3, 3, 2, 2, 2, 2, 0, 4,   42};   // two channels
        vecs[3] = '{1, 3, 3, 2, 2, 2, 2, 1, 4,   26};   // backprop
        vecs[4] = '{1, 3, 3, 2, 2, 0, 2, 0, 0,   1};    // kh = 0
        vecs[5] = '{1, 3, 3, 0, 2, 2, 2, 0, 0,   1};    // oh = 0
        vecs[6] = '{3, 5, 4, 2, 3, 3, 3, 0, 6,   176};  // larger
        vecs[7] = '{1, 3, 3, 2, 2, 2, 2, 0, 4,   31};   // stalled 5 cycles

        tap_ia1 = '{1, 2, 4, 5};
        tap_ia3 = '{4, 5, 7, 8};
        two_ia0 = '{0, 1, 3, 4, 9, 10, 12, 13};
`ifdef CONV_SEQ_BACKPROP_EN
        bp_wa0 = '{3, 2, 1, 0};
`else
        bp_wa0 = '{0, 1, 2, 3};
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", int'({busy, done, k_init, exec, k_fin, ia, wa}), 0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            if (v == 7) run(v, vecs[v], 0, 5, 1'b0);
            else        run(v, vecs[v], -1, 0, 1'b0);
            case (v)
                1: for (int k = 0; k < 4; k++) begin
                       chk($sformatf("tap ia px01 %0d", k), act_ia[4 + k], tap_ia1[k]);
                       chk($sformatf("tap wa px01 %0d", k), act_wa[4 + k], k);
                       chk($sformatf("tap ia px11 %0d", k), act_ia[12 + k], tap_ia3[k]);
                   end
                2: for (int k = 0; k < 8; k++) begin
                       chk($sformatf("two ia px00 %0d", k), act_ia[k], two_ia0[k]);
                       chk($sformatf("two wa px00 %0d", k), act_wa[k], k);
                   end
                3: for (int k = 0; k < 4; k++)
                       chk($sformatf("bp wa px00 %0d", k), act_wa[k], bp_wa0[k]);
                7: for (int k = 0; k < 4; k++)
                       chk($sformatf("stall ia px11 %0d", k), act_ia[12 + k], tap_ia3[k]);
                default: ;
            endcase
        end

        // Reset in the middle of EXEC, then a clean rerun.
        @(posedge clk); #1;
        drive_cfg(vecs[1]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_exec", int'(exec), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_outputs", int'({busy, done, k_init, exec, k_fin, ia, wa}), 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen = seen | int'({busy, k_fin, exec});
        end
        chk("post_rst_quiet", seen, 0);
        run(8, vecs[1], -1, 0, 1'b0);

        // Randomised configurations with noise on ignored inputs.
        for (int r = 0; r < 25; r++) begin
            rv.oh = $urandom_range(1, 3);
            rv.ow = $urandom_range(1, 3);
            rv.kh = $urandom_range(1, 3);
            rv.kw = $urandom_range(1, 3);
            rv.id = $urandom_range(1, 3);
            rv.iw = rv.ow + rv.kw - 1 + int'($urandom_range(0, 2));
            rv.ih = rv.oh + rv.kh - 1;
            rv.bp = 1'($urandom);
            rv.exp_fins = -1;
            rv.exp_done = -1;
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 4))
                    0: rv.oh = 0;
                    1: rv.ow = 0;
                    2: rv.id = 0;
                    3: rv.kh = 0;
                    default: rv.kw = 0;
                endcase
            end
            run(100 + r, rv, -1, 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/conv_seq.md
# conv_seq

Convolution loop sequencer for the `tiny_dnn_core` array. It walks output pixels, input channels and kernel taps, and drives `k_init`, `exec`, `ia`, `wa` and `k_fin` so that the 16 cores accumulate one output pixel per kernel pass. It stalls between pixels while the output drain reports `out_busy`. The block sits between the batch control (`start`/`done`) and the core/src-buffer datapath.

## Interface
- `IA_W`, 12: width of the src buffer address `ia`.
- `WA_W`, 10: width of the core weight address `wa`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin one sample; sampled only in IDLE.
- `backprop` in 1: selects the rotated-kernel weight order; sampled at `start`; see Configuration.
- `out_busy` in 1: output drain busy; blocks the next pixel's `k_init`.
- `id` in 4: input channel count.
- `is` in 10: input channel stride, equal to ih*iw.
- `iw` in 5: input width.
- `oh`, `ow` in 5 each: output height and width.
- `kh`, `kw` in 5 each: kernel height and width.
- `ks` in 10: kernel stride per channel, equal to kh*kw.
- `busy` out 1: high from the cycle after accepted `start` through the DONE cycle.
- `done` out 1: one-cycle pulse at the end of the sample.
- `k_init` out 1: one-cycle pulse that clears the core accumulators.
- `exec` out 1: high on every accumulate cycle.
- `ia` out IA_W: src buffer read address.
- `wa` out WA_W: weight read address.
- `k_fin` out 1: one-cycle pulse after the last `exec` of a pixel.

## Operation
- States: IDLE, WAIT, INIT, EXEC, FIN, DONE.
- **Latching:** at `start`, all dimension inputs and `backprop` are latched. Later changes are ignored until IDLE.
- **Zero dimension:** if any of `oh`, `ow`, `id`, `kh`, `kw` is 0 at `start`, go IDLE→DONE. `done` pulses and no `k_init` or `exec` is issued.
- **Transitions:**
  - IDLE→WAIT on `start`.
  - WAIT→INIT when `out_busy`=0.
  - INIT→EXEC.
  - EXEC→FIN after N = id·kh·kw exec cycles.
  - FIN→DONE if the pixel just finished was the last one (y=oh-1, x=ow-1).
  - Otherwise FIN→INIT if `out_busy`=0, or FIN→WAIT if `out_busy`=1.
  - DONE→IDLE.
- **Loop order:** pixel y (outer), then x, then channel c, then ky, then kx (innermost).
- **Addresses:** for each exec cycle:
  - `ia` = c·is + (y+ky)·iw + (x+kx), truncated to IA_W.
  - `wa` = c·ks + t, truncated to WA_W, where t = ky·kw+kx.
  - Addresses are generated by incremental adders, with no multipliers on the per-cycle path.
- **Idle values:** when `exec`=0, `ia` and `wa` hold 0.
- **Ignored start:** `start` is ignored unless the state is IDLE.

## Timing
- **Reset:** all outputs are registered. `rst` forces IDLE on the next edge, with `busy`, `done`, `k_init`, `exec`, `k_fin`=0 and `ia`=`wa`=0. Reset mid-sample aborts without emitting `k_fin`.
- **Start latency:** accepted `start` in cycle T gives `busy`=1 at T+1 (WAIT). The earliest `k_init` is at T+2.
- **Per-pixel timing:** `k_init` is 1 cycle, followed immediately by N consecutive `exec` cycles, then `k_fin` for 1 cycle. `exec` never gaps within a pixel.
- **Pixel throughput:** N+2 cycles per pixel when `out_busy` stays 0.
- **Stall:** `out_busy` is checked only in WAIT and FIN. Assertion during EXEC does not stall.
- **Completion:** `done` is asserted in the cycle after the final `k_fin`. `busy` falls the cycle after `done`.

## Configuration
- **`CONV_SEQ_BACKPROP_EN` defined:** when the latched `backprop`=1, the tap index becomes t' = ks-1-t, i.e. the kernel is rotated 180° for error propagation. `ia` is unchanged.
- **Macro undefined:** the `backprop` port exists but is ignored, and `wa` always uses t.

## Test plan
- **Minimal case:** oh=ow=id=kh=kw=1, is=ks=1, `start` at T → `k_init` at T+2, one `exec` at T+3 with `ia`=0, `wa`=0, `k_fin` at T+4, `done` at T+5.
- **Tap ordering:** iw=3, is=9, oh=ow=2, kh=kw=2, ks=4, id=1. Pixel (0,1) gives `ia` 1,2,4,5 and `wa` 0,1,2,3. Pixel (1,1) gives `ia` 4,5,7,8. Exactly 4 `k_fin` pulses are issued.
- **Two channels:** same setup with id=2. Pixel (0,0) gives `ia` 0,1,3,4,9,10,12,13 and `wa` 0..7.
- **Backprop (macro defined):** `backprop`=1 with the tap-ordering setup gives pixel (0,0) `wa` 3,2,1,0. With the macro undefined, `wa` is 0,1,2,3.
- **Stall:** `out_busy`=1 held for 5 cycles starting at FIN of pixel 0 → 5 WAIT cycles, then `k_init` the cycle after `out_busy` falls, and address sequences are unchanged.
- **Reset and zero dimension:** `rst` pulsed mid-EXEC → all outputs 0 the next cycle, and a new `start` runs the full sample cleanly. Separately, `start` with kh=0 → `done` pulse with no `k_init`.
